// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file access controller.
// Holds the FSM state enum, op and requester encodings, default sizes.
package rf_ctrl_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_NREG  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

endpackage

// File: rtl/rf_rr_arb.sv
// Combinational 2-way round-robin pick between requesters A and B.
// Ports: req_a, req_b, last (last served id) -> valid, winner (id).
module rf_rr_arb
    import rf_ctrl_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req_a | req_b;
        winner = ID_A;
        if (req_a && req_b) begin
            // on a tie the one not served last goes first
            winner = (last == ID_A) ? ID_B : ID_A;
        end else if (req_b) begin
            winner = ID_B;
        end
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// Two-port round-robin access controller for an external register bank.
// Ports: clk, reset (sync, active-low); per-requester req/op/addr/wdata
// in, gnt/done out; shared rdata; busy; bank side rf_sel, rf_din, rf_q.
module rf_access_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREG  = DEF_NREG,
    parameter int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic                  op_a,
    input  logic                  op_b,
    input  logic [AW-1:0]         addr_a,
    input  logic [AW-1:0]         addr_b,
    input  logic [WIDTH-1:0]      wdata_a,
    input  logic [WIDTH-1:0]      wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  done_a,
    output logic                  done_b,
    output logic [WIDTH-1:0]      rdata,
    output logic                  busy,
    output logic [NREG-1:0]       rf_sel,
    output logic [WIDTH-1:0]      rf_din,
    input  logic [NREG*WIDTH-1:0] rf_q
);

    state_t state;
    state_t state_nx;

    logic             win_q;
    logic             op_q;
    logic             last_q;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q;

    logic arb_valid;
    logic arb_win;

    rf_rr_arb u_arb (
        .req_a  (req_a),
        .req_b  (req_b),
        .last   (last_q),
        .valid  (arb_valid),
        .winner (arb_win)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            win_q   <= ID_A;
            op_q    <= OP_READ;
            last_q  <= ID_B;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && arb_valid) begin
                win_q   <= arb_win;
                op_q    <= (arb_win == ID_B) ? op_b    : op_a;
                addr_q  <= (arb_win == ID_B) ? addr_b  : addr_a;
                wdata_q <= (arb_win == ID_B) ? wdata_b : wdata_a;
            end
            if (state == ST_EXEC && op_q == OP_READ) begin
                rdata_q <= rf_q[int'(addr_q)*WIDTH +: WIDTH];
            end
            if (state == ST_DONE) begin
                last_q <= win_q;
            end
        end
    end

    always_comb begin
        state_nx = state;
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        done_a   = 1'b0;
        done_b   = 1'b0;
        rf_sel   = '0;
        rf_din   = '0;
        unique case (state)
            ST_IDLE: begin
                if (arb_valid) state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                gnt_a = (win_q == ID_A);
                gnt_b = (win_q == ID_B);
                if (op_q == OP_WRITE) begin
                    rf_sel[addr_q] = 1'b1;
                    rf_din         = wdata_q;
                end
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                done_a   = (win_q == ID_A);
                done_b   = (win_q == ID_B);
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy  = (state != ST_IDLE);
    assign rdata = rdata_q;

endmodule
